// File: rtl/imem_load_arbiter.sv
// Shares the instruction RAM port between the CPU (run mode) and the byte-serial host loader (load mode).
// Optional load checksum accumulator is built when IMEM_LOAD_CHECKSUM_EN is defined; otherwise checksum is tied to 0.
module imem_load_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_mode,
    input  logic              host_valid,
    input  logic [7:0]        host_byte,
    output logic              host_ready,
    input  logic              host_ptr_clr,
    output logic [ADDR_W-1:0] load_ptr,
    output logic              load_full,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [7:0]        checksum
);

    localparam int NB   = DATA_W / 8;
    localparam int BC_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BC_W-1:0]   BC_LAST = BC_W'(NB - 1);
    localparam logic [ADDR_W-1:0] PTR_MAX = '1;

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_COLLECT,
        S_COMMIT
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   load_ptr_q, load_ptr_d;
    logic [BC_W-1:0]     byte_cnt_q, byte_cnt_d;
    logic                load_full_q, load_full_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic                rvalid_q, rvalid_d;
`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [7:0]          checksum_q, checksum_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            load_ptr_q  <= '0;
            byte_cnt_q  <= '0;
            load_full_q <= 1'b0;
            word_q      <= '0;
            rvalid_q    <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
            checksum_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            load_ptr_q  <= load_ptr_d;
            byte_cnt_q  <= byte_cnt_d;
            load_full_q <= load_full_d;
            word_q      <= word_d;
            rvalid_q    <= rvalid_d;
`ifdef IMEM_LOAD_CHECKSUM_EN
            checksum_q  <= checksum_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        load_ptr_d  = load_ptr_q;
        byte_cnt_d  = byte_cnt_q;
        load_full_d = load_full_q;
        word_d      = word_q;
        rvalid_d    = 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
        checksum_d  = checksum_q;
`endif
        cpu_gnt     = 1'b0;
        host_ready  = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;

        case (state_q)
            S_RUN: begin
                if (load_mode) begin
                    // A read granted last cycle still owes its rvalid; give it one quiet cycle.
                    state_d = rvalid_q ? S_DRAIN : S_COLLECT;
                end else begin
                    cpu_gnt   = cpu_req;
                    mem_en    = cpu_req;
                    mem_we    = cpu_we;
                    mem_addr  = cpu_addr;
                    mem_wdata = cpu_wdata;
                    rvalid_d  = cpu_req & ~cpu_we;
                end
            end
            S_DRAIN: begin
                state_d = load_mode ? S_COLLECT : S_RUN;
            end
            S_COLLECT: begin
                if (!load_mode) begin
                    byte_cnt_d = '0;
                    state_d    = S_RUN;
                end else begin
                    host_ready = ~load_full_q & ~host_ptr_clr;
                    if (host_valid && host_ready) begin
                        word_d[{byte_cnt_q, 3'b000} +: 8] = host_byte;
`ifdef IMEM_LOAD_CHECKSUM_EN
                        checksum_d = checksum_q + host_byte;
`endif
                        if (byte_cnt_q == BC_LAST) begin
                            byte_cnt_d = '0;
                            state_d    = S_COMMIT;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 1'b1;
                        end
                    end
                end
            end
            S_COMMIT: begin
                mem_en     = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = load_ptr_q;
                mem_wdata  = word_q;
                byte_cnt_d = '0;
                if (load_ptr_q == PTR_MAX) begin
                    load_full_d = 1'b1;
                end else begin
                    load_ptr_d = load_ptr_q + 1'b1;
                end
                state_d = load_mode ? S_COLLECT : S_RUN;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase

        // Clear wins over pointer advance and byte capture; a COMMIT write still goes out this cycle.
        if (host_ptr_clr) begin
            load_ptr_d  = '0;
            byte_cnt_d  = '0;
            load_full_d = 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
            checksum_d  = '0;
`endif
        end
    end

    assign load_ptr   = load_ptr_q;
    assign load_full  = load_full_q;
    assign cpu_rvalid = rvalid_q;
    assign cpu_rdata  = rvalid_q ? mem_rdata : '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
    assign checksum   = checksum_q;
`else
    assign checksum   = 8'h00;
`endif

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Scoreboard bench for imem_load_arbiter: transaction-level model predicts RAM writes and CPU read data.
module tb_imem_load_arbiter;

    localparam int AW    = 2;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_mode = 1'b0;
    logic          host_valid = 1'b0;
    logic [7:0]    host_byte = '0;
    logic          host_ready;
    logic          host_ptr_clr = 1'b0;
    logic [AW-1:0] load_ptr;
    logic          load_full;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [7:0]    checksum;

    always #5 clk = ~clk;

    imem_load_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .load_mode(load_mode),
        .host_valid(host_valid), .host_byte(host_byte), .host_ready(host_ready),
        .host_ptr_clr(host_ptr_clr), .load_ptr(load_ptr), .load_full(load_full),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .checksum(checksum)
    );

    // Synchronous single-port RAM attached to the arbiter.
    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] ram_q = '0;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        ram_q <= ram[mem_addr];
        end
    end
    assign mem_rdata = ram_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
    typedef struct { int due; logic [DW-1:0] d; } rd_t;
    wr_t exp_wr[$];
    rd_t exp_rd[$];
    wr_t mon_w;
    rd_t mon_r;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int            m_ptr;
    int            m_cnt;
    bit            m_full;
    logic [7:0]    m_cks;
    logic [7:0]    m_part [4];
    logic [DW-1:0] ref_mem [DEPTH];
    int            last_gnt_cyc;
    int            last_acc_cyc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string nm, input string why);
        checks++;
        errors++;
        $display("FAIL %s: %s (cycle %0d)", nm, why, cyc);
    endtask

    function automatic logic [7:0] exp_cks();
`ifdef IMEM_LOAD_CHECKSUM_EN
        return m_cks;
`else
        return 8'h00;
`endif
    endfunction

    task automatic model_clear();
        m_ptr = 0; m_cnt = 0; m_full = 0; m_cks = 8'h00;
    endtask

    task automatic model_accept(input logic [7:0] b);
        logic [DW-1:0] w;
        wr_t e;
        m_cks = m_cks + b;
        m_part[m_cnt] = b;
        m_cnt++;
        if (m_cnt == 4) begin
            w = '0;
            for (int i = 0; i < 4; i++) w[8*i +: 8] = m_part[i];
            e.a = AW'(m_ptr);
            e.d = w;
            exp_wr.push_back(e);
            ref_mem[m_ptr] = w;
            if (m_ptr == DEPTH - 1) m_full = 1;
            else m_ptr++;
            m_cnt = 0;
        end
    endtask

    task automatic monitor_step();
        if (!rst_n) return;
        if (mem_en && mem_we) begin
            if (exp_wr.size() == 0) begin
                fail_now("wr_unexpected", $sformatf("actual addr=%0h data=%0h, required no write", mem_addr, mem_wdata));
            end else begin
                mon_w = exp_wr.pop_front();
                chk("wr_addr", 64'(mem_addr), 64'(mon_w.a));
                chk("wr_data", 64'(mem_wdata), 64'(mon_w.d));
                chk("ready_during_write", 64'(host_ready), 64'd0);
            end
        end
        if (cpu_rvalid) begin
            if (exp_rd.size() == 0) begin
                fail_now("rvalid_unexpected", $sformatf("actual data=%0h, required no rvalid", cpu_rdata));
            end else begin
                mon_r = exp_rd.pop_front();
                chk("rd_cycle", 64'(cyc), 64'(mon_r.due));
                chk("rd_data", 64'(cpu_rdata), 64'(mon_r.d));
            end
        end
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 0;
        host_valid = 1'b1;
        host_byte  = b;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (host_ready) begin
                ok = 1;
                last_acc_cyc = cyc;
                model_accept(b);
                break;
            end
        end
        @(posedge clk);
        #1;
        host_valid = 1'b0;
        if (!ok) fail_now("host_timeout", $sformatf("actual host_ready never 1, required byte %0h accepted", b));
    endtask

    task automatic cpu_acc(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit ok;
        rd_t r;
        wr_t w;
        ok = 0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cpu_gnt) begin
                ok = 1;
                last_gnt_cyc = cyc;
                if (we) begin
                    w.a = a; w.d = d;
                    exp_wr.push_back(w);
                    ref_mem[a] = d;
                end else begin
                    r.due = cyc + 1; r.d = ref_mem[a];
                    exp_rd.push_back(r);
                end
                break;
            end
        end
        @(posedge clk);
        #1;
        cpu_req = 1'b0; cpu_we = 1'b0;
        if (!ok) fail_now("cpu_timeout", "actual cpu_gnt never 1, required grant");
    endtask

    task automatic pulse_clr();
        host_ptr_clr = 1'b1;
        @(posedge clk);
        #1;
        host_ptr_clr = 1'b0;
        model_clear();
    endtask

    task automatic drop_load();
        load_mode = 1'b0;
        m_cnt = 0;
        settle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: actual no finish, required finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int r;
        for (int i = 0; i < DEPTH; i++) begin ram[i] = '0; ref_mem[i] = '0; end
        model_clear();
        last_gnt_cyc = 0;
        last_acc_cyc = 0;

        fork
            forever begin
                @(negedge clk);
                #1;
                monitor_step();
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_load_ptr", 64'(load_ptr), 64'd0);
        chk("rst_load_full", 64'(load_full), 64'd0);
        chk("rst_host_ready", 64'(host_ready), 64'd0);
        chk("rst_rvalid", 64'(cpu_rvalid), 64'd0);
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_cpu_gnt", 64'(cpu_gnt), 64'd0);
        chk("rst_checksum", 64'(checksum), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        settle();

        // Two full words from the host
        load_mode = 1'b1;
        for (int i = 1; i <= 8; i++) send_byte(8'(i * 8'h11));
        settle();
        chk("load_ptr_after_2w", 64'(load_ptr), 64'(m_ptr));
        drop_load();

        // Back-to-back reads return on consecutive cycles
        cpu_acc(1'b0, 2'd0, '0);
        cpu_acc(1'b0, 2'd1, '0);
        settle();

        // Load entry right after a granted read goes through DRAIN
        cpu_acc(1'b0, 2'd0, '0);
        n = last_gnt_cyc;
        load_mode = 1'b1;
        send_byte(8'h5A);
        chk("drain_first_byte_late", 64'(last_acc_cyc >= n + 3), 64'd1);
        send_byte(8'h5B);
        drop_load();

        // Partial word discarded; next load resumes at the kept pointer
        load_mode = 1'b1;
        for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i));
        settle();
        chk("load_ptr_after_resume", 64'(load_ptr), 64'(m_ptr));

        // Fill the last word and hold off further bytes
        for (int i = 0; i < 4; i++) send_byte(8'hC0 + 8'(i));
        settle();
        chk("load_full_set", 64'(load_full), 64'd1);
        chk("load_ptr_held", 64'(load_ptr), 64'(DEPTH - 1));
        chk("checksum_full", 64'(checksum), 64'(exp_cks()));
        host_valid = 1'b1;
        host_byte  = 8'h99;
        repeat (4) begin
            @(negedge clk);
            chk("full_holdoff", 64'(host_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        host_valid = 1'b0;

        pulse_clr();
        settle();
        chk("clr_load_ptr", 64'(load_ptr), 64'd0);
        chk("clr_load_full", 64'(load_full), 64'd0);
        chk("clr_checksum", 64'(checksum), 64'd0);
        send_byte(8'hFF);
        send_byte(8'h02);
        settle();
        chk("checksum_wrap", 64'(checksum), 64'(exp_cks()));
        drop_load();

        // Reset kills an in-flight read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 2'd1;
        @(negedge clk);
        chk("pre_rst_gnt", 64'(cpu_gnt), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        cpu_req = 1'b0;
        @(negedge clk);
        chk("rst_kills_rvalid", 64'(cpu_rvalid), 64'd0);
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        settle();

        // Randomized mix of CPU bursts, loads and clears
        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 4);
            if (r <= 1) begin
                n = $urandom_range(1, 6);
                for (int j = 0; j < n; j++)
                    cpu_acc(($urandom_range(0, 9) < 3), AW'($urandom_range(0, DEPTH - 1)), DW'($urandom));
            end else if (r <= 3) begin
                load_mode = 1'b1;
                n = $urandom_range(1, 10);
                for (int j = 0; j < n; j++) begin
                    if (!m_full) send_byte(8'($urandom));
                end
                if ($urandom_range(0, 7) == 0) pulse_clr();
                drop_load();
            end else begin
                pulse_clr();
                settle();
            end
            chk("rand_load_ptr", 64'(load_ptr), 64'(m_ptr));
            chk("rand_load_full", 64'(load_full), 64'(m_full));
            chk("rand_checksum", 64'(checksum), 64'(exp_cks()));
        end

        // Read everything back through the CPU port
        for (int a = 0; a < DEPTH; a++) cpu_acc(1'b0, AW'(a), '0);
        settle();
        chk("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
        chk("rd_queue_drained", 64'(exp_rd.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
